// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory slave: word-organised RAM, byte-lane writes, programmable wait states.
// Optional AHB_DMEM_ERR_EN enables the legality check and the two-cycle ERROR response.
module ahb_dmem_slave #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          strb_q;
  logic [31:0]         rdata_q;

  logic [31:0]         mem [2**ADDR_W];

  logic                accept, legal, we;
  logic [1:0]          size_eff, off_eff;
  logic [3:0]          strb_in;
  logic [ADDR_W-1:0]   word_in;
  logic [31:0]         mem_word, fwd_word;
  logic                unused_bits;

  assign unused_bits = ^{HTRANS[0], HADDR};

  assign accept  = HSEL & HTRANS[1] & HREADY & HREADYOUT;
  assign word_in = HADDR[ADDR_W+1:2];
  assign we      = (state_q == ST_IDLE) & phase_q & write_q;

  // Oversized accesses collapse to words and misaligned ones are forced aligned;
  // with the legality check enabled these cases never reach the RAM anyway.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    size_eff = (HSIZE > 3'd2) ? 2'd2 : HSIZE[1:0];
    off_eff  = 2'b00;
    strb_in  = 4'b1111;
    case (size_eff)
      2'd0: begin
        off_eff = HADDR[1:0];
        strb_in = 4'b0001 << off_eff;
      end
      2'd1: begin
        off_eff = {HADDR[1], 1'b0};
        strb_in = off_eff[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef AHB_DMEM_ERR_EN
  always_comb begin
    legal = 1'b1;
    if (HSIZE > 3'd2)                          legal = 1'b0;
    if (HSIZE == 3'd1 && HADDR[0])             legal = 1'b0;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)  legal = 1'b0;
    if ((HADDR >> (ADDR_W + 2)) != 32'd0)      legal = 1'b0;
  end
  assign HRESP = (state_q == ST_ERR1) || (state_q == ST_ERR2);
`else
  assign legal = 1'b1;
  assign HRESP = 1'b0;
`endif

  // A read whose address phase overlaps a write's completing data phase sees the new bytes.
  always_comb begin
    mem_word = mem[word_in];
    fwd_word = mem_word;
    for (int b = 0; b < 4; b++) begin
      if (we && addr_q == word_in && strb_q[b]) fwd_word[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_d = ST_IDLE;
        phase_d = 1'b0;
        if (accept) begin
          if (!legal) begin
            state_d = ST_ERR1;
          end else begin
            phase_d = 1'b1;
            if (WAIT_STATES != 0) begin
              state_d = ST_WAIT;
              cnt_d   = 4'(WAIT_STATES);
            end
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      phase_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      strb_q  <= 4'b0000;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      if (accept) begin
        write_q <= HWRITE;
        addr_q  <= word_in;
        strb_q  <= strb_in;
        if (legal) rdata_q <= fwd_word;
      end
    end
  end

  // NOTE: the RAM array has no reset; a pending write is dropped because phase_q clears asynchronously.
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
  assign HRDATA    = (state_q == ST_IDLE && phase_q && !write_q) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Directed bench for ahb_dmem_slave: one zero-wait and one three-wait-state instance.
// Expectations follow AHB_DMEM_ERR_EN as defined for the build.
module tb_ahb_dmem_slave;

  logic        CLK, RES;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] rdata0, rdata3;
  logic        rdy0, rdy3, resp0, resp3;

  int n_checks = 0;
  int n_err    = 0;

  ahb_dmem_slave #(.ADDR_W(14), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .RES(RES), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0)
  );

  ahb_dmem_slave #(.ADDR_W(14), .WAIT_STATES(3)) u_ws3 (
    .CLK(CLK), .RES(RES), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy3),
    .HRDATA(rdata3), .HREADYOUT(rdy3), .HRESP(resp3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge CLK);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
  endtask

  initial begin
    RES = 1'b1; hsel0 = 1'b0; hsel3 = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd2; hwdata = '0;

    // Reset
    repeat (2) cyc;
    check("rst_rdy0",   32'(rdy0),   32'd1);
    check("rst_resp0",  32'(resp0),  32'd0);
    check("rst_rdata0", rdata0,      32'd0);
    check("rst_rdy3",   32'(rdy3),   32'd1);
    RES = 1'b0;
    repeat (3) cyc;
    check("idle_rdy0",   32'(rdy0),  32'd1);
    check("idle_resp0",  32'(resp0), 32'd0);
    check("idle_rdata0", rdata0,     32'd0);
    check("idle_resp3",  32'(resp3), 32'd0);

    // Word write then back-to-back read with forwarding
    hsel0 = 1'b1;
    addr_phase(32'h100, 1'b1, 3'd2);
    check("t2_wr_addr_rdy", 32'(rdy0), 32'd1);
    cyc;
    hwdata = 32'hDEADBEEF;
    addr_phase(32'h100, 1'b0, 3'd2);
    check("t2_wr_data_rdy",   32'(rdy0), 32'd1);
    check("t2_wr_data_rdata", rdata0,    32'd0);
    cyc;
    htrans = 2'b00;
    check("t2_rd_data",  rdata0,     32'hDEADBEEF);
    check("t2_rd_rdy",   32'(rdy0),  32'd1);
    cyc;
    check("t2_idle_rdata", rdata0, 32'd0);

    // Byte lanes: word, byte, half, then forwarded read
    addr_phase(32'h40, 1'b1, 3'd2);
    cyc;
    hwdata = 32'h11223344;
    addr_phase(32'h41, 1'b1, 3'd0);
    cyc;
    hwdata = 32'hFFFFAAFF;
    addr_phase(32'h42, 1'b1, 3'd1);
    cyc;
    hwdata = 32'hBBCC7777;
    addr_phase(32'h40, 1'b0, 3'd2);
    cyc;
    htrans = 2'b00; hwdata = '0;
    check("t3_rd_fwd", rdata0, 32'hBBCCAA44);
    cyc;
    addr_phase(32'h41, 1'b0, 3'd0);
    cyc;
    htrans = 2'b00;
    check("t3_rd_ram", rdata0, 32'hBBCCAA44);
    cyc;

    // Errors (or aliasing / forced alignment when the check is disabled)
    addr_phase(32'h0, 1'b1, 3'd2);
    cyc;
    hwdata = 32'hCAFE0001; htrans = 2'b00;
    cyc;
    addr_phase(32'h102, 1'b1, 3'd2);
    cyc;
    hwdata = 32'h12345678; htrans = 2'b00;
`ifdef AHB_DMEM_ERR_EN
    check("t5_err1_rdy",  32'(rdy0),  32'd0);
    check("t5_err1_resp", 32'(resp0), 32'd1);
    cyc;
    check("t5_err2_rdy",   32'(rdy0),  32'd1);
    check("t5_err2_resp",  32'(resp0), 32'd1);
    check("t5_err2_rdata", rdata0,     32'd0);
    addr_phase(32'h100, 1'b0, 3'd2);
    cyc;
    htrans = 2'b00;
    check("t5_after_err_resp", 32'(resp0), 32'd0);
    check("t5_ram_unchanged",  rdata0,     32'hDEADBEEF);
    cyc;
    addr_phase(32'h0004_0000, 1'b0, 3'd2);
    cyc;
    htrans = 2'b00;
    check("t5_oor_err1_rdy",  32'(rdy0),  32'd0);
    check("t5_oor_err1_resp", 32'(resp0), 32'd1);
    cyc;
    check("t5_oor_err2_rdy",   32'(rdy0),  32'd1);
    check("t5_oor_err2_resp",  32'(resp0), 32'd1);
    check("t5_oor_err2_rdata", rdata0,     32'd0);
    cyc;
    check("t5_oor_done_resp", 32'(resp0), 32'd0);
`else
    check("t5_mis_rdy",  32'(rdy0),  32'd1);
    check("t5_mis_resp", 32'(resp0), 32'd0);
    cyc;
    addr_phase(32'h100, 1'b0, 3'd2);
    cyc;
    htrans = 2'b00;
    check("t5_mis_landed", rdata0, 32'h12345678);
    cyc;
    addr_phase(32'h0004_0000, 1'b0, 3'd2);
    cyc;
    htrans = 2'b00;
    check("t5_alias_rdata", rdata0,     32'hCAFE0001);
    check("t5_alias_resp",  32'(resp0), 32'd0);
`endif
    cyc;
    hsel0 = 1'b0;

    // Wait states on the WAIT_STATES=3 instance
    hsel3 = 1'b1;
    addr_phase(32'h0, 1'b1, 3'd2);
    cyc;
    htrans = 2'b00; hwdata = 32'h0000A5A5;
    for (int i = 0; i < 3; i++) begin
      check("t4_wr_stall", 32'(rdy3), 32'd0);
      cyc;
    end
    check("t4_wr_done", 32'(rdy3), 32'd1);
    cyc;
    addr_phase(32'h0, 1'b0, 3'd2);
    cyc;
    for (int i = 0; i < 3; i++) begin
      addr_phase(32'h40 + 32'(4 * i), 1'b0, 3'd2);
      check("t4_rd_stall", 32'(rdy3), 32'd0);
      cyc;
    end
    htrans = 2'b00;
    check("t4_rd_rdy",   32'(rdy3), 32'd1);
    check("t4_rd_rdata", rdata3,    32'h0000A5A5);
    cyc;
    check("t4_no_accept_rdy",   32'(rdy3), 32'd1);
    check("t4_no_accept_rdata", rdata3,    32'd0);

    // Reset during the wait of a write
    addr_phase(32'h8, 1'b1, 3'd2);
    cyc;
    htrans = 2'b00; hwdata = 32'h00000077;
    repeat (3) cyc;
    check("t6_old_wr_done", 32'(rdy3), 32'd1);
    cyc;
    addr_phase(32'h8, 1'b1, 3'd2);
    cyc;
    htrans = 2'b00; hwdata = 32'h00000005;
    check("t6_stall", 32'(rdy3), 32'd0);
    RES = 1'b1;
    #1;
    check("t6_rst_rdy",  32'(rdy3),  32'd1);
    check("t6_rst_resp", 32'(resp3), 32'd0);
    cyc;
    RES = 1'b0;
    cyc;
    addr_phase(32'h8, 1'b0, 3'd2);
    cyc;
    htrans = 2'b00;
    repeat (3) cyc;
    check("t6_rd_rdy",  32'(rdy3), 32'd1);
    check("t6_ram_kept", rdata3,   32'h00000077);
    cyc;
    hsel3 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
